// File: rtl/fpu_cvt_to_int.sv
// Single-precision to signed/unsigned 32-bit integer (fcvt.w.s / fcvt.wu.s); iterative right-align of SHIFT_STEP bits/cycle.
// Latency ceil(rsh/SHIFT_STEP)+1 edges from start; start_i is ignored while busy_o, results hold until the next done_o.
module fpu_cvt_to_int #(
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        is_unsigned_i,
  input  logic [2:0]  rounding_mode_i,
  input  logic [31:0] A_i,
  output logic [31:0] result_o,
  output logic [1:0]  flags_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND} state_e;

  localparam logic [4:0] STEP_L = 5'(SHIFT_STEP);

  state_e      state_q, state_d;
  logic        cap_en, shf_en, rnd_en;

  logic [31:0] mag_q, mag_d;
  logic        rnd_q, rnd_d;
  logic        stk_q, stk_d;
  logic [4:0]  rem_q, rem_d;
  logic        spec_q, spec_d;
  logic        nan_q, nan_d;
  logic        sign_q, sign_d;
  logic        uns_q, uns_d;
  logic [2:0]  rm_q, rm_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  flags_q, flags_d;
  logic        done_q, done_d;

  // Operand decode at capture
  logic [7:0]  exp_in;
  logic [22:0] mant_in;
  logic [23:0] sig_in;
  logic        cap_nan, cap_big, cap_sub, cap_left, cap_right;
  logic [3:0]  lsh;
  logic [4:0]  rsh;
  logic [31:0] cap_mag;

  always_comb begin
    exp_in    = A_i[30:23];
    mant_in   = A_i[22:0];
    sig_in    = {exp_in != 8'd0, mant_in};
    cap_nan   = (exp_in == 8'hFF) && (mant_in != 23'd0);
    cap_big   = (exp_in >= 8'd159);
    cap_sub   = (exp_in == 8'd0) && (mant_in != 23'd0);
    cap_left  = (exp_in >= 8'd150) && (exp_in <= 8'd158);
    cap_right = (exp_in != 8'd0) && (exp_in < 8'd150);
    lsh       = 4'(exp_in - 8'd150);
    rsh       = (exp_in < 8'd125) ? 5'd25 : 5'(8'd150 - exp_in);
    if (cap_left)
      cap_mag = {8'd0, sig_in} << lsh;
    else if (cap_right)
      cap_mag = {8'd0, sig_in};
    else
      cap_mag = 32'd0;
  end

  // One right-shift step over {mag[23:0], round}; everything below round folds into sticky
  logic [4:0]  amt;
  logic [24:0] ext, ext_sh, lost_mask;
  logic        lost;

  always_comb begin
    amt       = (rem_q < STEP_L) ? rem_q : STEP_L;
    ext       = {mag_q[23:0], rnd_q};
    ext_sh    = ext >> amt;
    lost_mask = ~(25'h1FF_FFFF << amt);
    lost      = |(ext & lost_mask);
  end

  // Rounding and range check
  logic        inexact, inc, ovf, nv, neg_sat;
  logic [32:0] mag33;
  logic [31:0] sat_res, rnd_res;
  logic [1:0]  rnd_flags;

  always_comb begin
    inexact = rnd_q | stk_q;
    case (rm_q)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign_q & inexact;
      3'd3:    inc = ~sign_q & inexact;
      3'd4:    inc = rnd_q;
      default: inc = rnd_q & (stk_q | mag_q[0]);
    endcase
    mag33 = {1'b0, mag_q} + {32'd0, inc};
    case ({uns_q, sign_q})
      2'b00:   ovf = (mag33 > 33'h0_7FFF_FFFF);
      2'b01:   ovf = (mag33 > 33'h0_8000_0000);
      2'b10:   ovf = mag33[32];
      default: ovf = (mag33 != 33'd0);
    endcase
    nv      = spec_q | ovf;
    neg_sat = sign_q & ~nan_q;
    if (uns_q)
      sat_res = neg_sat ? 32'h0000_0000 : 32'hFFFF_FFFF;
    else
      sat_res = neg_sat ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (nv)
      rnd_res = sat_res;
    else if (sign_q)
      rnd_res = ~mag33[31:0] + 32'd1;
    else
      rnd_res = mag33[31:0];
    rnd_flags = nv ? 2'b10 : {1'b0, inexact};
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = cap_right ? S_SHIFT : S_ROUND;
      S_SHIFT: if (rem_q == amt) state_d = S_ROUND;
      S_ROUND: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
    cap_en = (state_q == S_IDLE) && start_i;
    shf_en = (state_q == S_SHIFT);
    rnd_en = (state_q == S_ROUND);
  end

  always_comb begin
    mag_d    = mag_q;
    rnd_d    = rnd_q;
    stk_d    = stk_q;
    rem_d    = rem_q;
    spec_d   = spec_q;
    nan_d    = nan_q;
    sign_d   = sign_q;
    uns_d    = uns_q;
    rm_d     = rm_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = rnd_en;
    if (cap_en) begin
      mag_d  = cap_mag;
      rnd_d  = 1'b0;
      stk_d  = cap_sub;
      rem_d  = cap_right ? rsh : 5'd0;
      spec_d = cap_big;
      nan_d  = cap_nan;
      sign_d = A_i[31];
      uns_d  = is_unsigned_i;
      rm_d   = rounding_mode_i;
    end else if (shf_en) begin
      mag_d = {8'd0, ext_sh[24:1]};
      rnd_d = ext_sh[0];
      stk_d = stk_q | lost;
      rem_d = rem_q - amt;
    end
    if (rnd_en) begin
      result_d = rnd_res;
      flags_d  = rnd_flags;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mag_q    <= 32'd0;
      rnd_q    <= 1'b0;
      stk_q    <= 1'b0;
      rem_q    <= 5'd0;
      spec_q   <= 1'b0;
      nan_q    <= 1'b0;
      sign_q   <= 1'b0;
      uns_q    <= 1'b0;
      rm_q     <= 3'd0;
      result_q <= 32'd0;
      flags_q  <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      mag_q    <= mag_d;
      rnd_q    <= rnd_d;
      stk_q    <= stk_d;
      rem_q    <= rem_d;
      spec_q   <= spec_d;
      nan_q    <= nan_d;
      sign_q   <= sign_d;
      uns_q    <= uns_d;
      rm_q     <= rm_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign flags_o  = flags_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_fpu_cvt_to_int.sv
// Bench for fpu_cvt_to_int: directed vectors, randomized operands against an arithmetic reference, handshake and reset.
module tb_fpu_cvt_to_int;

  localparam int STEP = 4;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;
  localparam longint MAXU = 64'sd4294967295;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        is_unsigned_i;
  logic [2:0]  rounding_mode_i;
  logic [31:0] A_i;
  logic [31:0] result_o;
  logic [1:0]  flags_o;
  logic        busy_o;
  logic        done_o;

  int tests_run = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  fpu_cvt_to_int #(.SHIFT_STEP(STEP)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
    .is_unsigned_i(is_unsigned_i), .rounding_mode_i(rounding_mode_i), .A_i(A_i),
    .result_o(result_o), .flags_o(flags_o), .busy_o(busy_o), .done_o(done_o)
  );

  // Reference: exact integer part and remainder-versus-half comparison, then IEEE rounding and range clamp
  function automatic void ref_model(input logic [31:0] a, input logic uns, input logic [2:0] rm,
                                    output logic [31:0] res, output logic [1:0] flg, output int lat);
    int ex, e, sh;
    longint sig, q, rem, half, v;
    logic s, inexact, gt_half, eq_half, inc, nv;
    ex = int'(a[30:23]);
    s = a[31];
    sig = (ex == 0) ? longint'(a[22:0]) : longint'(a[22:0]) + 64'sd8388608;
    lat = 1; nv = 1'b0; inexact = 1'b0; res = 32'd0;
    gt_half = 1'b0; eq_half = 1'b0; q = 0;
    if (ex == 255 && a[22:0] != 23'd0) begin
      nv = 1'b1;
      res = uns ? 32'hFFFFFFFF : 32'h7FFFFFFF;
    end else if (ex >= 159) begin
      nv = 1'b1;
      if (s) res = uns ? 32'h0 : 32'h80000000;
      else   res = uns ? 32'hFFFFFFFF : 32'h7FFFFFFF;
    end else begin
      e = (ex == 0) ? -126 : ex - 127;
      if (e >= 23) begin
        q = sig <<< (e - 23);
      end else begin
        sh = 23 - e;
        if (sh <= 40) begin
          q = sig >>> sh;
          rem = sig - (q <<< sh);
          half = 64'sd1 <<< (sh - 1);
          gt_half = rem > half;
          eq_half = rem == half;
          inexact = rem != 0;
        end else begin
          inexact = sig != 0;
        end
        if (ex != 0) lat = 1 + (((sh > 25) ? 25 : sh) + STEP - 1) / STEP;
      end
      case (rm)
        3'd1:    inc = 1'b0;
        3'd2:    inc = s & inexact;
        3'd3:    inc = ~s & inexact;
        3'd4:    inc = gt_half | eq_half;
        default: inc = gt_half | (eq_half & q[0]);
      endcase
      v = q + longint'(inc);
      if (s) v = -v;
      if (!uns) begin
        if (v > MAXS)      begin nv = 1'b1; res = 32'h7FFFFFFF; end
        else if (v < MINS) begin nv = 1'b1; res = 32'h80000000; end
        else res = v[31:0];
      end else begin
        if (v < 0)         begin nv = 1'b1; res = 32'h0; end
        else if (v > MAXU) begin nv = 1'b1; res = 32'hFFFFFFFF; end
        else res = v[31:0];
      end
    end
    flg = nv ? 2'b10 : {1'b0, inexact};
  endfunction

  // Issues one conversion and returns the outputs and the number of edges from start edge to done
  task automatic run_op(input logic [31:0] a, input logic uns, input logic [2:0] rm,
                        output logic [31:0] res, output logic [1:0] flg, output int edges);
    @(negedge clk_i);
    A_i = a; is_unsigned_i = uns; rounding_mode_i = rm; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; A_i = $urandom; is_unsigned_i = $urandom_range(0, 1);
    rounding_mode_i = 3'($urandom_range(0, 7));
    edges = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk_i); #1;
      if (done_o) begin edges = n; break; end
    end
    res = result_o; flg = flags_o;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; start_i = 1'b0; is_unsigned_i = 1'b0; rounding_mode_i = 3'd0; A_i = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    tests_run++;
    if ({result_o, flags_o, busy_o, done_o} !== 36'd0) begin
      fails++;
      $display("FAIL reset_state: result=%h flags=%b busy=%b done=%b, want all 0", result_o, flags_o, busy_o, done_o);
    end
    @(negedge clk_i); reset_i = 1'b1;
  endtask

  typedef struct packed {
    logic [31:0] a; logic uns; logic [2:0] rm; logic [31:0] r; logic [1:0] f; logic [3:0] lat;
  } vec_t;

  task automatic test_directed();
    vec_t vq[$];
    logic [31:0] res; logic [1:0] flg; int edges;
    vq.push_back('{32'h3FC00000, 1'b0, 3'd0, 32'd2,        2'b01, 4'd7});
    vq.push_back('{32'h3FC00000, 1'b0, 3'd1, 32'd1,        2'b01, 4'd7});
    vq.push_back('{32'hBFC00000, 1'b0, 3'd2, 32'hFFFFFFFE, 2'b01, 4'd7});
    vq.push_back('{32'h40200000, 1'b0, 3'd0, 32'd2,        2'b01, 4'd7});
    vq.push_back('{32'h40200000, 1'b0, 3'd4, 32'd3,        2'b01, 4'd7});
    vq.push_back('{32'h40200000, 1'b0, 3'd3, 32'd3,        2'b01, 4'd7});
    vq.push_back('{32'h4F000000, 1'b0, 3'd0, 32'h7FFFFFFF, 2'b10, 4'd1});
    vq.push_back('{32'h4F000000, 1'b1, 3'd0, 32'h80000000, 2'b00, 4'd1});
    vq.push_back('{32'hCF000000, 1'b0, 3'd0, 32'h80000000, 2'b00, 4'd1});
    vq.push_back('{32'h7FC00000, 1'b0, 3'd0, 32'h7FFFFFFF, 2'b10, 4'd1});
    vq.push_back('{32'h7FC00000, 1'b1, 3'd0, 32'hFFFFFFFF, 2'b10, 4'd1});
    vq.push_back('{32'hFF800000, 1'b1, 3'd0, 32'h00000000, 2'b10, 4'd1});
    vq.push_back('{32'hBF000000, 1'b1, 3'd0, 32'h00000000, 2'b01, 4'd7});
    vq.push_back('{32'hBF000000, 1'b1, 3'd2, 32'h00000000, 2'b10, 4'd7});
    vq.push_back('{32'h00000001, 1'b0, 3'd3, 32'd1,        2'b01, 4'd1});
    vq.push_back('{32'h4B800001, 1'b0, 3'd0, 32'd16777218, 2'b00, 4'd1});
    vq.push_back('{32'h3FC00000, 1'b0, 3'd5, 32'd2,        2'b01, 4'd7});
    vq.push_back('{32'h3E800000, 1'b0, 3'd3, 32'd1,        2'b01, 4'd8});
    vq.push_back('{32'h80000000, 1'b1, 3'd0, 32'd0,        2'b00, 4'd1});
    vq.push_back('{32'h4F800000, 1'b1, 3'd0, 32'hFFFFFFFF, 2'b10, 4'd1});
    vq.push_back('{32'h4F7FFFFF, 1'b1, 3'd0, 32'hFFFFFF00, 2'b00, 4'd1});
    foreach (vq[i]) begin
      run_op(vq[i].a, vq[i].uns, vq[i].rm, res, flg, edges);
      tests_run++;
      if (edges !== int'(vq[i].lat)) begin
        fails++;
        $display("FAIL dir_latency[%0d] a=%h: got %0d edges, want %0d", i, vq[i].a, edges, vq[i].lat);
      end
      tests_run++;
      if (res !== vq[i].r) begin
        fails++;
        $display("FAIL dir_result[%0d] a=%h uns=%b rm=%0d: got %h, want %h", i, vq[i].a, vq[i].uns, vq[i].rm, res, vq[i].r);
      end
      tests_run++;
      if (flg !== vq[i].f) begin
        fails++;
        $display("FAIL dir_flags[%0d] a=%h uns=%b rm=%0d: got %b, want %b", i, vq[i].a, vq[i].uns, vq[i].rm, flg, vq[i].f);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, res, eres; logic [1:0] flg, eflg; int edges, elat;
    logic [7:0] ex; logic [22:0] m; logic uns; logic [2:0] rm;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       ex = 8'd0;
        1:       ex = 8'd255;
        2:       ex = 8'($urandom_range(150, 160));
        default: ex = 8'($urandom_range(115, 158));
      endcase
      m = 23'($urandom);
      if ($urandom_range(0, 2) == 0) m = m & 23'h7FF000;
      if ($urandom_range(0, 15) == 0) m = 23'd0;
      a = {1'($urandom), ex, m};
      uns = 1'($urandom_range(0, 1));
      rm = 3'($urandom_range(0, 7));
      ref_model(a, uns, rm, eres, eflg, elat);
      run_op(a, uns, rm, res, flg, edges);
      tests_run++;
      if (edges !== elat) begin
        fails++;
        $display("FAIL rnd_latency a=%h: got %0d edges, want %0d", a, edges, elat);
      end
      tests_run++;
      if (res !== eres) begin
        fails++;
        $display("FAIL rnd_result a=%h uns=%b rm=%0d: got %h, want %h", a, uns, rm, res, eres);
      end
      tests_run++;
      if (flg !== eflg) begin
        fails++;
        $display("FAIL rnd_flags a=%h uns=%b rm=%0d: got %b, want %b", a, uns, rm, flg, eflg);
      end
    end
  endtask

  task automatic test_back_to_back();
    int early, edges;
    early = 0;
    @(negedge clk_i);
    A_i = 32'h3FC00000; is_unsigned_i = 1'b0; rounding_mode_i = 3'd0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; A_i = 32'hDEADBEEF;
    tests_run++;
    if (busy_o !== 1'b1) begin fails++; $display("FAIL hs_busy_after_start: got %b, want 1", busy_o); end
    for (int n = 1; n <= 7; n++) begin
      if (n == 3) begin
        A_i = 32'h40400000; start_i = 1'b1;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0; A_i = 32'h12345678;
      if (n < 7 && done_o) early++;
    end
    tests_run++;
    if (early !== 0) begin fails++; $display("FAIL hs_early_done: got %0d early pulses, want 0", early); end
    tests_run++;
    if ({done_o, busy_o} !== 2'b10) begin
      fails++; $display("FAIL hs_done_cycle: done=%b busy=%b, want done=1 busy=0", done_o, busy_o);
    end
    tests_run++;
    if ({result_o, flags_o} !== {32'd2, 2'b01}) begin
      fails++; $display("FAIL hs_first_result: got %h/%b, want 00000002/01", result_o, flags_o);
    end
    A_i = 32'h40400000; rounding_mode_i = 3'd0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; A_i = 32'hCAFEF00D;
    edges = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk_i); #1;
      if (done_o) begin edges = n; break; end
    end
    tests_run++;
    if (edges !== 7) begin fails++; $display("FAIL hs_second_latency: got %0d edges, want 7", edges); end
    tests_run++;
    if ({result_o, flags_o} !== {32'd3, 2'b00}) begin
      fails++; $display("FAIL hs_second_result: got %h/%b, want 00000003/00", result_o, flags_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [1:0] flg; int edges, spurious;
    run_op(32'h3FC00000, 1'b0, 3'd0, res, flg, edges);
    @(negedge clk_i);
    A_i = 32'h3FC00000; is_unsigned_i = 1'b0; rounding_mode_i = 3'd0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    tests_run++;
    if (busy_o !== 1'b1) begin fails++; $display("FAIL rst_mid_busy: got %b, want 1", busy_o); end
    @(negedge clk_i); reset_i = 1'b0;
    #1;
    tests_run++;
    if ({result_o, flags_o, busy_o, done_o} !== 36'd0) begin
      fails++;
      $display("FAIL rst_mid_clear: result=%h flags=%b busy=%b done=%b, want all 0", result_o, flags_o, busy_o, done_o);
    end
    spurious = 0;
    for (int n = 0; n < 10; n++) begin
      if (n == 2) begin @(negedge clk_i); reset_i = 1'b1; end
      @(posedge clk_i); #1;
      if (done_o) spurious++;
    end
    tests_run++;
    if (spurious !== 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d done pulses, want 0", spurious); end
    run_op(32'h3FC00000, 1'b0, 3'd3, res, flg, edges);
    tests_run++;
    if ({res, flg} !== {32'd2, 2'b01} || edges !== 7) begin
      fails++; $display("FAIL rst_mid_restart: got %h/%b in %0d edges, want 00000002/01 in 7", res, flg, edges);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
